// File: rtl/btn_conditioner.sv
// Push-button conditioner: optional polarity inversion, 2-flop synchroniser,
// prescaled debounce and registered press/release pulses. Macro: BTN_ACTIVE_LOW_EN.
module btn_conditioner #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned STABLE   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     btn_raw,
    output logic [WIDTH-1:0]     btn,
    output logic [WIDTH-1:0]     btn_rise,
    output logic [WIDTH-1:0]     btn_fall,
    output logic [WIDTH-1:0]     dbg_pending_o,
    output logic [WIDTH*((STABLE > 1) ? $clog2(STABLE) : 1)-1:0] dbg_dcnt_o
);

    localparam int unsigned PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DW  = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [PCW-1:0] PCNT_LAST = PCW'(PRESCALE - 1);
    localparam logic [DW-1:0]  DCNT_LAST = DW'(STABLE - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [PCW-1:0]   pcnt_q;
    logic [PCW-1:0]   pcnt_d;
    logic             tick;

    db_state_e        state_q [WIDTH];
    logic [DW-1:0]    dcnt_q  [WIDTH];
    logic [WIDTH-1:0] btn_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

`ifdef BTN_ACTIVE_LOW_EN
    assign raw_in = ~btn_raw;
`else
    assign raw_in = btn_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // With PRESCALE=1 the counter is stuck at 0 == PCNT_LAST, so tick stays high.
    assign tick = (pcnt_q == PCNT_LAST);

    always_comb begin
        pcnt_d = pcnt_q + PCW'(1);
        if (tick) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    // Per-bit debounce FSM; btn and its edge pulses are registered on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                state_q[i] <= ST_IDLE;
                dcnt_q[i]  <= '0;
            end
            btn_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= '0;
            fall_q <= '0;
            if (tick) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (sync2_q[i] != btn_q[i]) begin
                                if (STABLE == 1) begin
                                    btn_q[i]  <= ~btn_q[i];
                                    rise_q[i] <= ~btn_q[i];
                                    fall_q[i] <= btn_q[i];
                                end else begin
                                    state_q[i] <= ST_PENDING;
                                    dcnt_q[i]  <= DW'(1);
                                end
                            end
                        end
                        ST_PENDING: begin
                            if (sync2_q[i] == btn_q[i]) begin
                                state_q[i] <= ST_IDLE;
                                dcnt_q[i]  <= '0;
                            end else if (dcnt_q[i] == DCNT_LAST) begin
                                btn_q[i]   <= ~btn_q[i];
                                rise_q[i]  <= ~btn_q[i];
                                fall_q[i]  <= btn_q[i];
                                state_q[i] <= ST_IDLE;
                                dcnt_q[i]  <= '0;
                            end else begin
                                dcnt_q[i] <= dcnt_q[i] + DW'(1);
                            end
                        end
                        default: begin
                            state_q[i] <= ST_IDLE;
                            dcnt_q[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign btn      = btn_q;
    assign btn_rise = rise_q;
    assign btn_fall = fall_q;

    always_comb begin
        dbg_pending_o = '0;
        dbg_dcnt_o    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            dbg_pending_o[i]       = (state_q[i] == ST_PENDING);
            dbg_dcnt_o[i*DW +: DW] = dcnt_q[i];
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (PRESCALE=4, STABLE=3): stimulus pushes expected
// pulse events into a queue, a negedge monitor pops and compares them.
module tb_btn_conditioner;

    localparam int W        = 4;
    localparam int PRESCALE = 4;
    localparam int STABLE   = 3;
    localparam int DW       = 2;
    localparam int EW       = 16 + 3 * W;

`ifdef BTN_ACTIVE_LOW_EN
    localparam logic [W-1:0] INV = '1;
`else
    localparam logic [W-1:0] INV = '0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    btn_raw;
    logic [W-1:0]    btn;
    logic [W-1:0]    btn_rise;
    logic [W-1:0]    btn_fall;
    logic [W-1:0]    dbg_pending;
    logic [W*DW-1:0] dbg_dcnt;

    int              cyc;
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];
    logic [W-1:0]    mon_btn;

    btn_conditioner #(
        .WIDTH    (W),
        .PRESCALE (PRESCALE),
        .STABLE   (STABLE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn           (btn),
        .btn_rise      (btn_rise),
        .btn_fall      (btn_fall),
        .dbg_pending_o (dbg_pending),
        .dbg_dcnt_o    (dbg_dcnt)
    );

    // Clock and cycle index: cycle 0 is the cycle in which reset is released.
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic set_raw(input logic [W-1:0] pressed);
        btn_raw = pressed ^ INV;
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc < c && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc < c) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: reached cycle %0d, required %0d", cyc, c);
        end
    endtask

    task automatic push_exp(input int c, input logic [W-1:0] b,
                            input logic [W-1:0] r, input logic [W-1:0] f);
        logic [15:0] c16;
        c16 = 16'(c);
        exp_q.push_back({c16, b, r, f});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the head of exp_q; btn level tracked.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        if (reset) begin
            mon_btn = '0;
        end else begin
            if ((btn_rise | btn_fall) != '0) begin
                got = {cyc[15:0], btn, btn_rise, btn_fall};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cyc=%0d btn=%b rise=%b fall=%b, expected no pulse",
                             cyc, btn, btn_rise, btn_fall);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL pulse_event: got cyc=%0d btn=%b rise=%b fall=%b, expected cyc=%0d btn=%b rise=%b fall=%b",
                                 got[EW-1:3*W], got[3*W-1:2*W], got[2*W-1:W], got[W-1:0],
                                 e[EW-1:3*W], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
                    end
                    mon_btn = e[3*W-1:2*W];
                end
            end
            checks++;
            if (btn !== mon_btn) begin
                errors++;
                $display("FAIL btn_level: cyc=%0d got %b, expected %b", cyc, btn, mon_btn);
            end
        end
    end

    initial begin
        // Reset with all buttons held for 3 cycles.
        reset = 1'b1;
        set_raw(4'b1111);
        repeat (3) @(negedge clk);
        check("reset_btn", 32'(btn), 32'h0);
        check("reset_rise", 32'(btn_rise), 32'h0);
        check("reset_fall", 32'(btn_fall), 32'h0);
        check("reset_pending", 32'(dbg_pending), 32'h0);
        check("reset_dcnt", 32'(dbg_dcnt), 32'h0);
        // sync at cycle 2, ticks 3/7/11, btn visible at cycle 12.
        push_exp(12, 4'b1111, 4'b1111, 4'b0000);
        reset = 1'b0;
        wait_cyc(16);

        reset = 1'b1;
        set_raw(4'b0000);
        repeat (2) @(negedge clk);
        check("reset2_btn", 32'(btn), 32'h0);
        reset = 1'b0;

        // Clean press/release on bit 0.
        wait_cyc(1);
        set_raw(4'b0001);
        push_exp(12, 4'b0001, 4'b0001, 4'b0000);
        wait_cyc(21);
        set_raw(4'b0000);
        push_exp(32, 4'b0000, 4'b0000, 4'b0001);

        // Bounce on bit 1: high on tick 39, low on tick 43, steady from tick 47.
        wait_cyc(37);
        set_raw(4'b0010);
        wait_cyc(40);
        set_raw(4'b0000);
        wait_cyc(44);
        set_raw(4'b0010);
        push_exp(56, 4'b0010, 4'b0010, 4'b0000);

        // Independence: bits 2,3 together, bit 0 one prescale period later.
        wait_cyc(60);
        set_raw(4'b1110);
        push_exp(72, 4'b1110, 4'b1100, 4'b0000);
        wait_cyc(64);
        set_raw(4'b1111);
        push_exp(76, 4'b1111, 4'b0001, 4'b0000);
        wait_cyc(80);
        set_raw(4'b1000);
        push_exp(92, 4'b1000, 4'b0000, 4'b0111);

        // Async reset while bit 0 is pending with dcnt=2.
        wait_cyc(100);
        set_raw(4'b1001);
        wait_cyc(108);
        check("mid_pending", 32'(dbg_pending), 32'h1);
        check("mid_dcnt", 32'(dbg_dcnt), 32'h02);
        check("mid_btn", 32'(btn), 32'h8);
        wait_cyc(109);
        #2;
        reset = 1'b1;
        #1;
        check("async_btn", 32'(btn), 32'h0);
        check("async_rise", 32'(btn_rise), 32'h0);
        check("async_fall", 32'(btn_fall), 32'h0);
        check("async_pending", 32'(dbg_pending), 32'h0);
        check("async_dcnt", 32'(dbg_dcnt), 32'h0);
        repeat (3) @(negedge clk);
        // Buttons held through release are requalified from scratch.
        push_exp(12, 4'b1001, 4'b1001, 4'b0000);
        reset = 1'b0;
        wait_cyc(20);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
